// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the memory bridge: FSM state encoding,
// command encoding on dm_cmd, and the width of the wait-state counter.
package mem_bridge_pkg;

  localparam int unsigned WCNT_W = 4;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times the memory wait states.
// Ports:
//   clk, rst  - clock and synchronous active-high reset (clears count)
//   load      - load load_val (has priority over dec)
//   load_val  - value to load
//   dec       - decrement by one; saturates at zero
//   zero      - count is zero
module mem_wait_counter
  import mem_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WCNT_W-1:0] load_val,
  input  logic              dec,
  output logic              zero
);

  logic [WCNT_W-1:0] cnt_q;
  logic [WCNT_W-1:0] cnt_d;

  // Next count: load wins over decrement; never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - WCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_bridge.sv
// Control-unit to data-memory bridge. Accepts one CU request at a time,
// drives a single-cycle memory strobe followed by WAIT_CYC wait states,
// captures read data on entry to DONE and pulses cu_ack for one cycle.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   cu_req/cu_we/cu_addr/wdata  - CU request, sampled only in IDLE
//   cu_rdata, cu_ack            - read result (held) and completion pulse
//   cu_busy                     - transaction in flight (decoded from state)
//   dm_en/cmd/addr/wdata        - memory strobe and held request fields
//   dm_rdata                    - memory read data
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cu_req,
  input  logic              cu_we,
  input  logic [ADDR_W-1:0] cu_addr,
  input  logic [DATA_W-1:0] cu_wdata,
  output logic [DATA_W-1:0] cu_rdata,
  output logic              cu_ack,
  output logic              cu_busy,
  output logic              dm_en,
  output logic              dm_cmd,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata
);

  state_e            state_q, state_d;
  logic              dm_en_q, dm_en_d;
  logic              dm_cmd_q, dm_cmd_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;
  logic [DATA_W-1:0] cu_rdata_q, cu_rdata_d;
  logic              cu_ack_q, cu_ack_d;

  logic              accept;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;

  // Loaded on leaving ACCESS so WAIT lasts exactly WAIT_CYC cycles.
  mem_wait_counter u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (WCNT_W'(WAIT_CYC - 1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign accept = (state_q == IDLE) && cu_req;

  // Next-state logic; requests outside IDLE are dropped, not queued.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cu_req) state_d = ACCESS;
      end
      ACCESS: begin
        if (WAIT_CYC == 0) begin
          state_d = DONE;
        end else begin
          state_d  = WAIT;
          cnt_load = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_zero) state_d = DONE;
        else          cnt_dec = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_comb begin
    dm_en_d    = (state_d == ACCESS);
    cu_ack_d   = (state_d == DONE);
    dm_cmd_d   = dm_cmd_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    cu_rdata_d = cu_rdata_q;
    if (accept) begin
      dm_cmd_d   = cu_we;
      dm_addr_d  = cu_addr;
      dm_wdata_d = (cu_we == CMD_WRITE) ? cu_wdata : '0;
    end
    // Capture read data on the edge entering DONE; writes leave it alone.
    if ((state_d == DONE) && (state_q != DONE) && (dm_cmd_q == CMD_READ)) begin
      cu_rdata_d = dm_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dm_en_q    <= 1'b0;
      dm_cmd_q   <= CMD_READ;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      cu_rdata_q <= '0;
      cu_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      dm_en_q    <= dm_en_d;
      dm_cmd_q   <= dm_cmd_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      cu_rdata_q <= cu_rdata_d;
      cu_ack_q   <= cu_ack_d;
    end
  end

  assign cu_busy  = (state_q != IDLE);
  assign dm_en    = dm_en_q;
  assign dm_cmd   = dm_cmd_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;
  assign cu_rdata = cu_rdata_q;
  assign cu_ack   = cu_ack_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge. Four 8-bit instances (WAIT_CYC 0,1,3,15)
// and one 16/12-bit instance (WAIT_CYC 1) share stimulus; 'sel' picks the
// instance that sees cu_req and whose outputs are observed.
module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cu_req;
  logic        cu_we;
  logic [15:0] cu_addr;
  logic [15:0] cu_wdata;
  int          sel;

  logic [7:0]  rd8 [4];
  logic [7:0]  addr8 [4];
  logic [7:0]  wd8 [4];
  logic        ack8 [4];
  logic        busy8 [4];
  logic        en8 [4];
  logic        cmd8 [4];

  logic [15:0] rd16;
  logic [11:0] addr16;
  logic [15:0] wd16;
  logic        ack16, busy16, en16, cmd16;

  logic        obs_ack, obs_busy, obs_en, obs_cmd;
  logic [15:0] obs_addr, obs_wdata, obs_rdata;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut8
    mem_bridge #(
      .DATA_W   (8),
      .ADDR_W   (8),
      .WAIT_CYC ((g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 15)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .cu_req   (cu_req && (sel == g)),
      .cu_we    (cu_we),
      .cu_addr  (cu_addr[7:0]),
      .cu_wdata (cu_wdata[7:0]),
      .cu_rdata (rd8[g]),
      .cu_ack   (ack8[g]),
      .cu_busy  (busy8[g]),
      .dm_en    (en8[g]),
      .dm_cmd   (cmd8[g]),
      .dm_addr  (addr8[g]),
      .dm_wdata (wd8[g]),
      .dm_rdata (addr8[g] ^ 8'h99)
    );
  end

  mem_bridge #(
    .DATA_W   (16),
    .ADDR_W   (12),
    .WAIT_CYC (1)
  ) u_dut16 (
    .clk      (clk),
    .rst      (rst),
    .cu_req   (cu_req && (sel == 4)),
    .cu_we    (cu_we),
    .cu_addr  (cu_addr[11:0]),
    .cu_wdata (cu_wdata),
    .cu_rdata (rd16),
    .cu_ack   (ack16),
    .cu_busy  (busy16),
    .dm_en    (en16),
    .dm_cmd   (cmd16),
    .dm_addr  (addr16),
    .dm_wdata (wd16),
    .dm_rdata ({4'h0, addr16} ^ 16'hB110)
  );

  always_comb begin
    obs_ack   = ack16;
    obs_busy  = busy16;
    obs_en    = en16;
    obs_cmd   = cmd16;
    obs_addr  = {4'h0, addr16};
    obs_wdata = wd16;
    obs_rdata = rd16;
    if (sel < 4) begin
      obs_ack   = ack8[sel[1:0]];
      obs_busy  = busy8[sel[1:0]];
      obs_en    = en8[sel[1:0]];
      obs_cmd   = cmd8[sel[1:0]];
      obs_addr  = {8'h00, addr8[sel[1:0]]};
      obs_wdata = {8'h00, wd8[sel[1:0]]};
      obs_rdata = {8'h00, rd8[sel[1:0]]};
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s sel=%0d t=%0t: got 0x%0h expected 0x%0h", name, sel, $time, act, exp);
    end
  endfunction

  function automatic int wc_of(input int s);
    case (s)
      0:       return 0;
      1:       return 1;
      2:       return 3;
      3:       return 15;
      default: return 1;
    endcase
  endfunction

  // Scoreboard: every cu_ack pops the read data expected for that transaction.
  always @(negedge clk) begin
    if (obs_ack) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_ack sel=%0d t=%0t: got ack=1 expected no ack", sel, $time);
      end else begin
        chk("sb_rdata", 32'(obs_rdata), 32'(sb_q.pop_front()));
      end
    end
  end

  // One transaction starting before the next posedge; returns at the
  // negedge of the first IDLE cycle. Inputs are scrambled after acceptance.
  task automatic do_txn(input int s, input logic we, input logic [15:0] a,
                        input logic [15:0] wd, input logic [15:0] rd_exp);
    int          wc;
    logic [15:0] amask, dmask;
    wc    = wc_of(s);
    amask = (s == 4) ? 16'h0FFF : 16'h00FF;
    dmask = (s == 4) ? 16'hFFFF : 16'h00FF;
    sel      = s;
    cu_req   = 1'b1;
    cu_we    = we;
    cu_addr  = a;
    cu_wdata = wd;
    sb_q.push_back(rd_exp);
    @(posedge clk);
    #1;
    cu_req   = 1'b0;
    cu_we    = ~we;
    cu_addr  = ~a;
    cu_wdata = ~wd;
    for (int c = 1; c <= wc + 3; c++) begin
      @(negedge clk);
      chk("cu_busy", 32'(obs_busy), 32'(c <= wc + 2));
      chk("dm_en",   32'(obs_en),   32'(c == 1));
      chk("cu_ack",  32'(obs_ack),  32'(c == wc + 2));
      if (c <= wc + 1) begin
        chk("dm_cmd",   32'(obs_cmd),   32'(we));
        chk("dm_addr",  32'(obs_addr),  32'(a & amask));
        chk("dm_wdata", 32'(obs_wdata), we ? 32'(wd & dmask) : 32'd0);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int s = 0; s < 5; s++) begin
      sel = s;
      @(negedge clk);
      chk({tag, "_busy"},  32'(obs_busy),  32'd0);
      chk({tag, "_ack"},   32'(obs_ack),   32'd0);
      chk({tag, "_en"},    32'(obs_en),    32'd0);
      chk({tag, "_cmd"},   32'(obs_cmd),   32'd0);
      chk({tag, "_addr"},  32'(obs_addr),  32'd0);
      chk({tag, "_wdata"}, 32'(obs_wdata), 32'd0);
      chk({tag, "_rdata"}, 32'(obs_rdata), 32'd0);
    end
  endtask

  typedef struct {
    int          s;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // Reads return addr ^ 0x99 (8-bit) or {0,addr} ^ 0xB110 (16-bit).
    vecs[0] = '{1, 1'b0, 16'h003C, 16'h0000, 16'h00A5};
    vecs[1] = '{0, 1'b1, 16'h0010, 16'h005A, 16'h0000};
    vecs[2] = '{0, 1'b0, 16'h0000, 16'h0000, 16'h0099};
    vecs[3] = '{0, 1'b1, 16'h00FF, 16'h00C3, 16'h0099};
    vecs[4] = '{1, 1'b1, 16'h003C, 16'h0011, 16'h00A5};
    vecs[5] = '{2, 1'b0, 16'h00FF, 16'h0000, 16'h0066};
    vecs[6] = '{3, 1'b0, 16'h007E, 16'h0000, 16'h00E7};
    vecs[7] = '{4, 1'b0, 16'h0FFF, 16'h0000, 16'hBEEF};
    vecs[8] = '{4, 1'b1, 16'h0123, 16'h1234, 16'hBEEF};
    vecs[9] = '{4, 1'b0, 16'h0000, 16'h0000, 16'hB110};

    rst      = 1'b1;
    cu_req   = 1'b0;
    cu_we    = 1'b0;
    cu_addr  = '0;
    cu_wdata = '0;
    sel      = 0;

    // Reset state on every instance.
    repeat (2) @(negedge clk);
    chk_all_zero("rst");
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single transactions.
    for (int i = 0; i < 10; i++) begin
      do_txn(vecs[i].s, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
    end

    // cu_req held high on WAIT_CYC=3 with new inputs every cycle:
    // accepts at edges 0, 6, 12; inputs presented at edge e are 0x40+e / 0x80+e.
    sel      = 2;
    cu_req   = 1'b1;
    cu_we    = 1'b0;
    cu_addr  = 16'h0040;
    cu_wdata = 16'h0080;
    sb_q.push_back(16'h00D9);
    for (int c = 1; c <= 18; c++) begin
      int          n, p;
      logic        we_n;
      logic [15:0] a_n;
      @(negedge clk);
      n    = (c - 1) / 6;
      p    = (c - 1) % 6 + 1;
      we_n = ((6 * n) % 4) >= 2;
      a_n  = 16'(16'h0040 + 6 * n);
      chk("thr_en",   32'(obs_en),   32'(p == 1));
      chk("thr_ack",  32'(obs_ack),  32'(p == 5));
      chk("thr_busy", 32'(obs_busy), 32'(p != 6));
      if (p <= 4) begin
        chk("thr_cmd",   32'(obs_cmd),   32'(we_n));
        chk("thr_addr",  32'(obs_addr),  32'(a_n));
        chk("thr_wdata", 32'(obs_wdata), we_n ? 32'(16'h0080 + 6 * n) : 32'd0);
      end
      cu_addr  = 16'(16'h0040 + c);
      cu_wdata = 16'(16'h0080 + c);
      cu_we    = (c % 4) >= 2;
      if (c == 6)  sb_q.push_back(16'h00D9);
      if (c == 12) sb_q.push_back(16'h00D5);
      if (c == 18) cu_req = 1'b0;
    end

    // Reset in WAIT on WAIT_CYC=15, with cu_req also high at the reset edge.
    sel      = 3;
    cu_req   = 1'b1;
    cu_we    = 1'b0;
    cu_addr  = 16'h0055;
    cu_wdata = 16'h0000;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) cu_req = 1'b0;
    end
    chk("rstw_busy_before", 32'(obs_busy), 32'd1);
    rst    = 1'b1;
    cu_req = 1'b1;
    @(negedge clk);
    chk("rstw_busy", 32'(obs_busy), 32'd0);
    chk("rstw_en",   32'(obs_en),   32'd0);
    chk("rstw_ack",  32'(obs_ack),  32'd0);
    chk("rstw_addr", 32'(obs_addr), 32'd0);
    rst    = 1'b0;
    cu_req = 1'b0;
    chk_all_zero("rstw");
    repeat (20) @(negedge clk);

    // Normal operation resumes; rdata was cleared by reset.
    do_txn(3, 1'b0, 16'h0020, 16'h0000, 16'h00B9);
    do_txn(1, 1'b1, 16'h003C, 16'h0077, 16'h0000);

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL expose these parameters:
- DATA_W, default 8: data bus width.
- ADDR_W, default 8: address width.
- WAIT_CYC, default 1: memory wait states, legal range 0..15.
REQ-003 The block SHALL expose these ports, listed as name, direction, width, meaning:
- clk, in, 1: rising-edge clock.
- rst, in, 1: synchronous active-high reset.
- cu_req, in, 1: CU access request.
- cu_we, in, 1: 1 = write, 0 = read.
- cu_addr, in, ADDR_W: CU address.
- cu_wdata, in, DATA_W: CU write data.
- cu_rdata, out, DATA_W: read result.
- cu_ack, out, 1: one-cycle completion pulse.
- cu_busy, out, 1: transaction in flight.
- dm_en, out, 1: memory access strobe.
- dm_cmd, out, 1: 1 = write, 0 = read.
- dm_addr, out, ADDR_W: memory address.
- dm_wdata, out, DATA_W: memory write data.
- dm_rdata, in, DATA_W: memory read data.
REQ-004 The block SHALL replace bidirectional data buses with separate unidirectional read and write buses; no tristate logic is permitted.

Function
REQ-005 The FSM SHALL have exactly four states: IDLE, ACCESS, WAIT, DONE.
REQ-006 In IDLE with cu_req=1 at a clock edge, the block SHALL latch cu_we, cu_addr and cu_wdata, then enter ACCESS.
REQ-007 In IDLE with cu_req=0, the block SHALL remain in IDLE.
REQ-008 ACCESS SHALL last exactly one cycle with dm_en=1.
- WAIT_CYC=0: next state is DONE.
- Otherwise: next state is WAIT.
REQ-009 WAIT SHALL last exactly WAIT_CYC cycles, counted by a 4-bit down-counter loaded with WAIT_CYC-1, then go to DONE.
REQ-010 dm_en SHALL be 1 only in ACCESS.
REQ-011 dm_cmd, dm_addr and dm_wdata SHALL hold the latched values, stable from ACCESS through the last WAIT cycle.
REQ-012 dm_wdata SHALL be 0 for reads.
REQ-013 Read capture: on the edge leaving the last ACCESS or WAIT cycle into DONE, cu_rdata SHALL register dm_rdata.
REQ-014 cu_rdata SHALL hold that value until the next read completes; writes SHALL leave cu_rdata unchanged.
REQ-015 DONE SHALL last one cycle with cu_ack=1, then return to IDLE.
REQ-016 Latency: cu_ack SHALL be high in the cycle WAIT_CYC+2 cycles after the accepting edge.
REQ-017 Throughput: the next request SHALL be acceptable at the edge ending DONE+1, i.e. one access per WAIT_CYC+3 cycles.
REQ-018 cu_busy SHALL be 1 in every state except IDLE.
REQ-019 cu_req asserted while busy SHALL be ignored, not queued; the CU must hold or re-present it.
REQ-020 cu_req held high continuously SHALL produce back-to-back transactions, each re-latching the inputs current at its IDLE edge.
REQ-021 Input changes after acceptance SHALL NOT affect an in-flight transaction.
REQ-022 Addresses SHALL pass through unmodified, with no wrap or translation; all widths follow the parameters with no truncation.

Reset
REQ-023 When rst=1 at a clock edge, the state SHALL become IDLE and every output and register SHALL clear:
- cu_ack=0, cu_busy=0, cu_rdata=0;
- dm_en=0, dm_cmd=0, dm_addr=0, dm_wdata=0;
- wait counter = 0.
REQ-024 Reset during ACCESS, WAIT or DONE SHALL abort the transaction with no cu_ack and no cu_rdata update.
REQ-025 dm_en SHALL be 0 in the cycle after the reset edge.
REQ-026 rst SHALL take priority over cu_req at the same edge.

Structure
REQ-027 Package mem_bridge_pkg SHALL hold:
- the state enum (IDLE, ACCESS, WAIT, DONE);
- CMD_READ=1'b0 and CMD_WRITE=1'b1;
- the wait-counter width of 4.
REQ-028 Sub-module mem_wait_counter SHALL implement the loadable 4-bit down-counter with a zero flag; it is the only sub-module.
REQ-029 All outputs SHALL be registered except cu_busy, which is decoded from the state.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Read, WAIT_CYC=1, addr 0x3C, memory returns 0xA5 -> dm_en pulses once with dm_cmd=0; cu_ack 3 cycles after acceptance; cu_rdata=0xA5.
- Write, WAIT_CYC=0, addr 0x10, data 0x5A -> dm_en for one cycle with dm_cmd=1, dm_wdata=0x5A; cu_ack 2 cycles after acceptance; cu_rdata unchanged.
- WAIT_CYC=15, read -> dm_addr stable for 16 cycles; cu_ack at cycle 17.
- cu_req held high with new addr/data each cycle -> exactly one transaction per 6 cycles (WAIT_CYC=3); in-flight values never change mid-transaction.
- rst asserted during WAIT -> no cu_ack; all outputs 0 next cycle; next request completes normally.
- DATA_W=16, ADDR_W=12, read of 0xBEEF at 0xFFF -> cu_rdata=0xBEEF; dm_addr=0xFFF.
